dcache_tagv_nway: RTL and testbench

Parametrised N-way tag/valid array for the L1 data cache. It returns registered per-way hit detection and a replacement victim for each set lookup, and it accepts fills, per-line invalidates and a one-cycle whole-cache flush. Valid bits and tree pseudo-LRU state are held in flops and cleared by reset; tags are held in per-way simple dual-port BRAM.

---
 rtl/dcache_tagv_nway_if.sv | 40 ++++
 rtl/dcache_tagv_nway.sv | 124 ++++++++++++
 tb/tb_dcache_tagv_nway.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_tagv_nway_if.sv
// Request/response bundle between the L1 data cache controller and its tag/valid array.
// The controller owns the master side; the array is the slave.
interface dcache_tagv_nway_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int TAG_WIDTH  = 20,
    parameter int WAYS       = 4,
    parameter int WAY_W      = $clog2(WAYS)
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [TAG_WIDTH-1:0]  cmp_tag;
    logic                  lru_upd;
    logic                  rd_vld;
    logic [WAYS-1:0]       hit;
    logic                  hit_any;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      victim_way;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WAY_W-1:0]      wr_way;
    logic [TAG_WIDTH-1:0]  wr_tag;
    logic                  inv_en;
    logic [ADDR_WIDTH-1:0] inv_addr;
    logic [WAY_W-1:0]      inv_way;
    logic                  flush;

    modport master (
        output rd_en, rd_addr, cmp_tag, lru_upd,
        output wr_en, wr_addr, wr_way, wr_tag,
        output inv_en, inv_addr, inv_way, flush,
        input  rd_vld, hit, hit_any, hit_way, victim_way
    );

    modport slave (
        input  rd_en, rd_addr, cmp_tag, lru_upd,
        input  wr_en, wr_addr, wr_way, wr_tag,
        input  inv_en, inv_addr, inv_way, flush,
        output rd_vld, hit, hit_any, hit_way, victim_way
    );
endinterface

// File: rtl/dcache_tagv_nway.sv
// N-way tag/valid array: BRAM tags, flop valid bits and tree PLRU, one-cycle lookup
// with per-way hit, encoded hit way and replacement victim.
module dcache_tagv_nway #(
    parameter int ADDR_WIDTH = 6,
    parameter int TAG_WIDTH  = 20,
    parameter int WAYS       = 4,
    parameter int WAY_W      = $clog2(WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    dcache_tagv_nway_if.slave    bus
);
    localparam int SETS  = 1 << ADDR_WIDTH;
    localparam int NODES = WAYS - 1;

    logic [TAG_WIDTH-1:0]  r_tag_mem [WAYS][SETS];
    logic [TAG_WIDTH-1:0]  r_tag_rd  [WAYS];
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic                  r_rd_vld;
    logic [WAYS-1:0]       r_valid [SETS];
    logic [NODES-1:0]      r_plru  [SETS];

    logic                  w_wr_ok;
    logic [WAYS-1:0]       w_set_valid;
    logic [WAYS-1:0]       w_hit;
    logic [WAY_W-1:0]      w_hit_way;
    logic [WAY_W-1:0]      w_victim;
    logic                  w_hit_upd;
    logic [NODES-1:0]      w_plru_hit;
    logic [NODES-1:0]      w_plru_wr_base;
    logic [NODES-1:0]      w_plru_wr;

    // Heap-ordered tree: node 0 is the root, children of n are 2n+1 / 2n+2.
    // A node bit points toward the less recently used subtree (0 = left).
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [WAY_W-1:0] way);
        logic [WAY_W-1:0] node;
        node = '0;
        for (int l = 0; l < WAY_W; l++) begin
            bits[node] = ~way[WAY_W-1-l];
            node = (node << 1) + WAY_W'(1) + WAY_W'(way[WAY_W-1-l]);
        end
        return bits;
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] v;
        node = '0;
        v    = '0;
        for (int l = 0; l < WAY_W; l++) begin
            v[WAY_W-1-l] = bits[node];
            node = (node << 1) + WAY_W'(1) + WAY_W'(bits[node]);
        end
        return v;
    endfunction

    assign w_wr_ok = bus.wr_en & ~bus.flush;

    // Tag BRAMs: synchronous read with write-first forwarding on an address/way match.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (w_wr_ok && bus.wr_way == WAY_W'(w))
                r_tag_mem[w][bus.wr_addr] <= bus.wr_tag;
            if (bus.rd_en)
                r_tag_rd[w] <= (w_wr_ok && bus.wr_way == WAY_W'(w) && bus.wr_addr == bus.rd_addr)
                               ? bus.wr_tag : r_tag_mem[w][bus.rd_addr];
        end
        if (bus.rd_en)
            r_raddr <= bus.rd_addr;
    end

    always_comb begin
        w_set_valid = r_valid[r_raddr];
        w_victim    = plru_victim(r_plru[r_raddr]);
        for (int i = WAYS - 1; i >= 0; i--)
            if (!w_set_valid[i]) w_victim = WAY_W'(i);
        w_hit     = '0;
        w_hit_way = '0;
        for (int i = 0; i < WAYS; i++)
            w_hit[i] = w_set_valid[i] && (r_tag_rd[i] == bus.cmp_tag);
        for (int i = WAYS - 1; i >= 0; i--)
            if (w_hit[i]) w_hit_way = WAY_W'(i);
    end

    // A fill to the set just updated by a hit builds on the hit-updated bits.
    assign w_hit_upd      = r_rd_vld && (|w_hit) && bus.lru_upd;
    assign w_plru_hit     = plru_touch(r_plru[r_raddr], w_hit_way);
    assign w_plru_wr_base = (w_hit_upd && bus.wr_addr == r_raddr) ? w_plru_hit : r_plru[bus.wr_addr];
    assign w_plru_wr      = plru_touch(w_plru_wr_base, bus.wr_way);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_plru[s]  <= '0;
            end
        end else begin
            r_rd_vld <= bus.rd_en;
            if (bus.flush) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[s] <= '0;
                    r_plru[s]  <= '0;
                end
            end else begin
                if (w_hit_upd)
                    r_plru[r_raddr] <= w_plru_hit;
                if (bus.inv_en)
                    r_valid[bus.inv_addr][bus.inv_way] <= 1'b0;
                if (bus.wr_en) begin
                    r_valid[bus.wr_addr][bus.wr_way] <= 1'b1;
                    r_plru[bus.wr_addr]              <= w_plru_wr;
                end
            end
        end
    end

    assign bus.rd_vld     = r_rd_vld;
    assign bus.hit        = r_rd_vld ? w_hit : '0;
    assign bus.hit_any    = r_rd_vld & (|w_hit);
    assign bus.hit_way    = r_rd_vld ? w_hit_way : '0;
    assign bus.victim_way = r_rd_vld ? w_victim : '0;
endmodule

// File: tb/tb_dcache_tagv_nway.sv
// Bench for dcache_tagv_nway: directed scenarios plus random traffic, all checked
// against an array-level model of tags, valid bits and tree PLRU.
module tb_dcache_tagv_nway;
    localparam int AW    = 6;
    localparam int TW    = 20;
    localparam int WAYS  = 4;
    localparam int WAY_W = 2;
    localparam int SETS  = 1 << AW;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    dcache_tagv_nway_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .WAYS(WAYS), .WAY_W(WAY_W)) bus ();

    dcache_tagv_nway #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .WAYS(WAYS), .WAY_W(WAY_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: tree nodes numbered 1..WAYS-1, node n has children 2n and 2n+1;
    // a node value of 1 means the right subtree holds the next victim.
    bit [TW-1:0] m_tag   [WAYS][SETS];
    bit          m_valid [WAYS][SETS];
    bit          m_plru  [SETS][WAYS];
    bit          p_pend;
    int          p_addr;
    bit          e_any;
    int          e_way;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < WAYS; n++) m_plru[s][n] = 1'b0;
        p_pend = 1'b0;
    endtask

    // Making a way MRU points every node on its path at the opposite half.
    task automatic m_touch(input int s, input int way);
        for (int l = 0; l < WAY_W; l++)
            m_plru[s][(1 << l) + (way >> (WAY_W - l))] = ((way >> (WAY_W - 1 - l)) & 1) == 0;
    endtask

    function automatic int m_victim(input int s);
        int node, v;
        for (int w = 0; w < WAYS; w++)
            if (!m_valid[w][s]) return w;
        node = 1;
        v    = 0;
        for (int l = 0; l < WAY_W; l++) begin
            v    = v * 2 + int'(m_plru[s][node]);
            node = node * 2 + int'(m_plru[s][node]);
        end
        return v;
    endfunction

    task automatic check_out();
        logic [WAYS-1:0] eh;
        eh    = '0;
        e_way = 0;
        if (p_pend) begin
            for (int w = WAYS - 1; w >= 0; w--)
                if (m_valid[w][p_addr] && m_tag[w][p_addr] == bus.cmp_tag) begin
                    eh[w] = 1'b1;
                    e_way = w;
                end
            e_any = |eh;
            chk("rd_vld", 32'(bus.rd_vld), 32'd1);
            chk("hit", 32'(bus.hit), 32'(eh));
            chk("hit_any", 32'(bus.hit_any), 32'(e_any));
            chk("hit_way", 32'(bus.hit_way), 32'(e_way));
            chk("victim", 32'(bus.victim_way), 32'(m_victim(p_addr)));
        end else begin
            e_any = 1'b0;
            chk("rd_vld_idle", 32'(bus.rd_vld), 32'd0);
        end
    endtask

    task automatic model_edge();
        if (p_pend && e_any && bus.lru_upd) m_touch(p_addr, e_way);
        if (bus.flush) begin
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) m_valid[w][s] = 1'b0;
            for (int s = 0; s < SETS; s++)
                for (int n = 0; n < WAYS; n++) m_plru[s][n] = 1'b0;
        end else begin
            if (bus.inv_en) m_valid[bus.inv_way][bus.inv_addr] = 1'b0;
            if (bus.wr_en) begin
                m_tag[bus.wr_way][bus.wr_addr]   = bus.wr_tag;
                m_valid[bus.wr_way][bus.wr_addr] = 1'b1;
                m_touch(int'(bus.wr_addr), int'(bus.wr_way));
            end
        end
        p_pend = bus.rd_en;
        p_addr = int'(bus.rd_addr);
    endtask

    task automatic tick();
        #1;
        check_out();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.inv_en  = 1'b0;
        bus.flush   = 1'b0;
        bus.lru_upd = 1'b0;
    endtask

    task automatic fill(input int addr, input int way, input logic [TW-1:0] tag);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_way  = WAY_W'(way);
        bus.wr_tag  = tag;
        tick();
    endtask

    task automatic lookup_expect(input string name, input int addr, input logic [TW-1:0] tag,
                                 input bit upd, input logic [WAYS-1:0] exp_hit,
                                 input int exp_way, input int exp_vic);
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(addr);
        tick();
        bus.cmp_tag = tag;
        bus.lru_upd = upd;
        #1;
        chk({name, "_vld"}, 32'(bus.rd_vld), 32'd1);
        chk({name, "_hit"}, 32'(bus.hit), 32'(exp_hit));
        chk({name, "_way"}, 32'(bus.hit_way), 32'(exp_way));
        if (exp_vic >= 0) chk({name, "_vic"}, 32'(bus.victim_way), 32'(exp_vic));
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.cmp_tag = '0; bus.lru_upd = 1'b0;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_way = '0; bus.wr_tag = '0;
        bus.inv_en = 1'b0; bus.inv_addr = '0; bus.inv_way = '0; bus.flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 32'(bus.rd_vld), 32'd0);
        chk("rst_hit", 32'(bus.hit), 32'd0);
        chk("rst_any", 32'(bus.hit_any), 32'd0);
        chk("rst_way", 32'(bus.hit_way), 32'd0);
        chk("rst_vic", 32'(bus.victim_way), 32'd0);
        rst = 1'b0;

        lookup_expect("cold", 5, 20'h0, 1'b0, 4'b0000, 0, 0);

        fill(3, 2, 20'hABCDE);
        lookup_expect("fill_hit", 3, 20'hABCDE, 1'b0, 4'b0100, 2, 0);
        lookup_expect("fill_miss", 3, 20'hABCDF, 1'b0, 4'b0000, 0, 0);

        for (int w = 0; w < WAYS; w++) fill(7, w, 20'h70 + TW'(w));
        lookup_expect("vic_full", 7, 20'hFFFFF, 1'b0, 4'b0000, 0, 0);
        lookup_expect("vic_touch", 7, 20'h70, 1'b1, 4'b0001, 0, 0);
        lookup_expect("vic_plru", 7, 20'hFFFFF, 1'b0, 4'b0000, 0, 2);

        bus.rd_en = 1'b1; bus.rd_addr = 6'd9;
        bus.wr_en = 1'b1; bus.wr_addr = 6'd9; bus.wr_way = 2'd1; bus.wr_tag = 20'h12345;
        tick();
        bus.cmp_tag = 20'h12345;
        #1;
        chk("coll_hit", 32'(bus.hit), 32'h2);
        chk("coll_way", 32'(bus.hit_way), 32'd1);
        tick();

        bus.inv_en = 1'b1; bus.inv_addr = 6'd3; bus.inv_way = 2'd2;
        tick();
        lookup_expect("inv", 3, 20'hABCDE, 1'b0, 4'b0000, 0, 0);

        bus.flush = 1'b1;
        tick();
        lookup_expect("flush7", 7, 20'h70, 1'b0, 4'b0000, 0, 0);
        lookup_expect("flush9", 9, 20'h12345, 1'b0, 4'b0000, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            bus.rd_en   = $urandom_range(0, 1) == 1;
            bus.rd_addr = AW'($urandom_range(0, 3));
            if (p_pend && $urandom_range(0, 1) == 1)
                bus.cmp_tag = m_tag[$urandom_range(0, WAYS - 1)][p_addr];
            else
                bus.cmp_tag = TW'($urandom_range(1, 4));
            bus.lru_upd  = $urandom_range(0, 1) == 1;
            bus.wr_en    = $urandom_range(0, 9) < 3;
            bus.wr_addr  = AW'($urandom_range(0, 3));
            bus.wr_way   = WAY_W'($urandom_range(0, WAYS - 1));
            bus.wr_tag   = TW'($urandom_range(1, 4));
            bus.inv_en   = $urandom_range(0, 99) < 15;
            bus.inv_addr = AW'($urandom_range(0, 3));
            bus.inv_way  = WAY_W'($urandom_range(0, WAYS - 1));
            bus.flush    = $urandom_range(0, 99) < 2;
            tick();
        end
        tick();

        fill(2, 1, 20'h00222);
        lookup_expect("pre_rst", 2, 20'h00222, 1'b0, 4'b0010, 1, -1);
        bus.rd_en = 1'b1; bus.rd_addr = 6'd2;
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rd_en = 1'b0;
        #1;
        chk("rst_mid_vld", 32'(bus.rd_vld), 32'd0);
        chk("rst_mid_hit", 32'(bus.hit), 32'd0);
        rst = 1'b0;
        model_reset();
        lookup_expect("post_rst", 2, 20'h00222, 1'b0, 4'b0000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
